// File: rtl/fp16_mult_norm_if.sv
// Stage-1 to stage-2 FP16 multiplier bus: upstream operand/product handshake
// plus the downstream packed-result handshake.
interface fp16_mult_norm_if;
    // valid/ready: a beat moves on a rising edge where valid && ready; the
    // sender holds its payload and valid steady until that edge.
    logic        in_valid;
    logic        in_ready;
    logic [15:0] ao;
    logic [15:0] bo;
    logic [15:0] po;
    logic [19:0] tm;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        ovf;
    logic        unf;
    logic        inexact;
    logic        nan;

    modport master (
        output in_valid, ao, bo, po, tm, out_ready,
        input  in_ready, out_valid, result, ovf, unf, inexact, nan
    );

    modport slave (
        input  in_valid, ao, bo, po, tm, out_ready,
        output in_ready, out_valid, result, ovf, unf, inexact, nan
    );
endinterface

// File: rtl/fp16_mult_norm.sv
// FP16 multiplier stage 2: rebuilds the significand product, normalizes,
// rounds to nearest-even and resolves specials in a two-register pipeline.
module fp16_mult_norm #(
    parameter logic [4:0]  BIAS = 5'd15,
    parameter logic [15:0] QNAN = 16'h7E00
) (
    input logic             clk,
    input logic             rst,
    fp16_mult_norm_if.slave bus
);
    logic va, vb, adv_b, load_a;

    assign adv_b         = !vb || bus.out_ready;
    assign load_a        = !va || adv_b;
    assign bus.in_ready  = load_a;
    assign bus.out_valid = vb;

    // Stage A decode
    logic [4:0]        ea, eb;
    logic [9:0]        fa, fb;
    logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic signed [6:0] exp_in;
    logic [21:0]       sig_in;
    logic              unused_po;

    assign ea     = bus.ao[14:10];
    assign eb     = bus.bo[14:10];
    assign fa     = bus.ao[9:0];
    assign fb     = bus.bo[9:0];
    assign a_zero = (ea == 5'd0);
    assign b_zero = (eb == 5'd0);
    assign a_inf  = (ea == 5'd31) && (fa == 10'd0);
    assign b_inf  = (eb == 5'd31) && (fb == 10'd0);
    assign a_nan  = (ea == 5'd31) && (fa != 10'd0);
    assign b_nan  = (eb == 5'd31) && (fb != 10'd0);
    // Widen before adding so the biased sum cannot wrap the way a 5-bit sum would.
    assign exp_in = $signed({2'b00, ea}) + $signed({2'b00, eb}) - $signed({2'b00, BIAS});
    assign sig_in = 22'h100000 + {2'b00, fa, 10'd0} + {2'b00, fb, 10'd0} + {2'b00, bus.tm};
    assign unused_po = ^bus.po[14:0];

    logic signed [6:0] a_exp;
    logic [21:0]       a_sig;
    logic              a_sign, a_spec_nan, a_spec_inf, a_spec_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            va          <= 1'b0;
            a_exp       <= '0;
            a_sig       <= '0;
            a_sign      <= 1'b0;
            a_spec_nan  <= 1'b0;
            a_spec_inf  <= 1'b0;
            a_spec_zero <= 1'b0;
        end else if (load_a) begin
            va <= bus.in_valid;
            if (bus.in_valid) begin
                a_exp       <= exp_in;
                a_sig       <= sig_in;
                a_sign      <= bus.po[15];
                a_spec_nan  <= a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero);
                a_spec_inf  <= a_inf || b_inf;
                a_spec_zero <= a_zero || b_zero;
            end
        end
    end

    // Stage B: normalize, round, pack
    logic [9:0]        m_pre;
    logic              g, s, rnd;
    logic [10:0]       m_sum;
    logic signed [6:0] e_norm, e_rnd;
    logic [15:0]       res_n;
    logic              ovf_n, unf_n, inx_n, nan_n;

    always_comb begin
        m_pre  = a_sig[19:10];
        g      = a_sig[9];
        s      = |a_sig[8:0];
        e_norm = a_exp;
        if (a_sig[21]) begin
            m_pre  = a_sig[20:11];
            g      = a_sig[10];
            s      = |a_sig[9:0];
            e_norm = a_exp + 7'sd1;
        end
        rnd   = g && (s || m_pre[0]);
        m_sum = {1'b0, m_pre} + {10'd0, rnd};
        e_rnd = e_norm + (m_sum[10] ? 7'sd1 : 7'sd0);

        res_n = {a_sign, e_rnd[4:0], m_sum[9:0]};
        ovf_n = 1'b0;
        unf_n = 1'b0;
        inx_n = g || s;
        nan_n = 1'b0;
        if (e_rnd >= 7'sd31) begin
            res_n = {a_sign, 15'h7C00};
            ovf_n = 1'b1;
            inx_n = 1'b1;
        end else if (e_rnd <= 7'sd0) begin
            res_n = {a_sign, 15'h0000};
            unf_n = 1'b1;
            inx_n = 1'b1;
        end
        // Specials override all arithmetic flags.
        if (a_spec_nan || a_spec_inf || a_spec_zero) begin
            ovf_n = 1'b0;
            unf_n = 1'b0;
            inx_n = 1'b0;
            if (a_spec_nan) begin
                res_n = QNAN;
                nan_n = 1'b1;
            end else if (a_spec_inf) begin
                res_n = {a_sign, 15'h7C00};
            end else begin
                res_n = {a_sign, 15'h0000};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vb          <= 1'b0;
            bus.result  <= '0;
            bus.ovf     <= 1'b0;
            bus.unf     <= 1'b0;
            bus.inexact <= 1'b0;
            bus.nan     <= 1'b0;
        end else if (adv_b) begin
            vb <= va;
            if (va) begin
                bus.result  <= res_n;
                bus.ovf     <= ovf_n;
                bus.unf     <= unf_n;
                bus.inexact <= inx_n;
                bus.nan     <= nan_n;
            end
        end
    end
endmodule

// File: tb/tb_fp16_mult_norm.sv
// Bench for fp16_mult_norm: directed cases, stalls, mid-flight reset and
// randomized traffic against an arithmetic reference model.
module tb_fp16_mult_norm;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_total = 0;
    int   n_bad   = 0;
    int   bp_mode = 0;   // 0: out_ready=1, 1: random, 2: driven by the test

    logic [19:0] exp_q[$];   // {nan, inexact, unf, ovf, result}

    fp16_mult_norm_if bus_if ();

    fp16_mult_norm #(.BIAS(5'd15), .QNAN(16'h7E00)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: exact integer significand product, rounded by remainder comparison.
    function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b, input logic sgn);
        int ea, eb, fa, fb, prod, sh, q, rem, half, e;
        bit a_nan, b_nan, a_inf, b_inf, a_z, b_z, inx;
        ea = int'(a[14:10]); eb = int'(b[14:10]);
        fa = int'(a[9:0]);   fb = int'(b[9:0]);
        a_z = (ea == 0); b_z = (eb == 0);
        a_inf = (ea == 31) && (fa == 0); b_inf = (eb == 31) && (fb == 0);
        a_nan = (ea == 31) && (fa != 0); b_nan = (eb == 31) && (fb != 0);
        if (a_nan || b_nan || (a_inf && b_z) || (b_inf && a_z)) return {4'b1000, 16'h7E00};
        if (a_inf || b_inf) return {4'b0000, sgn, 15'h7C00};
        if (a_z || b_z)     return {4'b0000, sgn, 15'h0000};
        prod = (1024 + fa) * (1024 + fb);
        e    = ea + eb - 15;
        sh   = 10;
        if (prod >= (1 << 21)) begin sh = 11; e = e + 1; end
        q    = prod >> sh;
        rem  = prod - (q << sh);
        half = 1 << (sh - 1);
        inx  = (rem != 0);
        if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
        if (q == 2048) begin q = 1024; e = e + 1; end
        if (e >= 31) return {4'b0101, sgn, 15'h7C00};
        if (e <= 0)  return {4'b0110, sgn, 15'h0000};
        return {1'b0, inx, 2'b00, sgn, 5'(e), 10'(q - 1024)};
    endfunction

    task automatic send(input logic [15:0] a, input logic [15:0] b, input bit push);
        int waitc = 0;
        logic sgn;
        @(negedge clk);
        sgn = a[15] ^ b[15];
        bus_if.in_valid = 1'b1;
        bus_if.ao = a;
        bus_if.bo = b;
        bus_if.po = {sgn, 15'($urandom)};
        bus_if.tm = {10'd0, a[9:0]} * {10'd0, b[9:0]};
        #1;
        while (!bus_if.in_ready && waitc < 1000) begin
            @(negedge clk);
            #1;
            waitc++;
        end
        check("accept", {31'd0, bus_if.in_ready}, 32'd1);
        if (push) exp_q.push_back(model(a, b, sgn));
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        bus_if.in_valid = 1'b0;
    endtask

    function automatic logic [15:0] rand_op();
        logic [4:0] e;
        logic [9:0] f;
        int r;
        r = $urandom_range(0, 9);
        if (r == 0)      e = 5'd0;
        else if (r == 1) e = 5'd31;
        else             e = 5'($urandom_range(1, 30));
        f = 10'($urandom);
        if ($urandom_range(0, 3) == 0) f = 10'd0;
        return {1'($urandom), e, f};
    endfunction

    always @(negedge clk) begin
        if (bp_mode == 1)      bus_if.out_ready = 1'($urandom_range(0, 1));
        else if (bp_mode == 0) bus_if.out_ready = 1'b1;
    end

    // Monitor: scoreboard pop on transfer, stability check while stalled.
    logic [20:0] held_val;
    bit          held_v = 0;
    always @(negedge clk) begin
        logic [20:0] cur;
        #2;
        cur = {bus_if.out_valid, bus_if.nan, bus_if.inexact, bus_if.unf, bus_if.ovf, bus_if.result};
        if (rst) begin
            held_v = 0;
        end else begin
            if (held_v) check("hold", {11'd0, cur}, {11'd0, held_val});
            if (bus_if.out_valid && bus_if.out_ready) begin
                check("q_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) check("result", {12'd0, cur[19:0]}, {12'd0, exp_q.pop_front()});
                held_v = 0;
            end else if (bus_if.out_valid) begin
                held_v   = 1;
                held_val = cur;
            end else begin
                held_v = 0;
            end
        end
    end

    initial begin
        int drain;
        bus_if.in_valid  = 1'b0;
        bus_if.ao        = '0;
        bus_if.bo        = '0;
        bus_if.po        = '0;
        bus_if.tm        = '0;
        bus_if.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
        check("rst_result", {16'd0, bus_if.result}, 32'd0);
        check("rst_flags", {28'd0, bus_if.nan, bus_if.inexact, bus_if.unf, bus_if.ovf}, 32'd0);
        check("rst_in_ready", {31'd0, bus_if.in_ready}, 32'd1);

        // T1 with latency: item sits in stage A after the accept edge, output after the next.
        send(16'h3C00, 16'h3C00, 1);
        idle();
        #1;
        check("lat_a", {31'd0, bus_if.out_valid}, 32'd0);
        @(negedge clk);
        #1;
        check("lat_b", {31'd0, bus_if.out_valid}, 32'd1);
        check("t1_result", {16'd0, bus_if.result}, 32'h3C00);

        // T2..T4
        send(16'h3E00, 16'h3E00, 1);
        send(16'h7BFF, 16'h7BFF, 1);
        send(16'h0400, 16'h0400, 1);
        send(16'h7C00, 16'h0000, 1);
        send(16'hFC00, 16'h3C00, 1);
        send(16'h3C01, 16'h3C01, 1);
        send(16'h3BFF, 16'h3C01, 1);
        idle();
        repeat (4) @(negedge clk);

        // T5: stall with back-to-back traffic
        bp_mode = 2;
        bus_if.out_ready = 1'b0;
        send(16'h3E00, 16'h3E00, 1);
        send(16'h3E00, 16'h3E00, 1);
        @(negedge clk);
        #1;
        check("t5_in_ready_low", {31'd0, bus_if.in_ready}, 32'd0);
        fork
            begin
                send(16'h3E00, 16'h3E00, 1);
                send(16'h3E00, 16'h3E00, 1);
                idle();
            end
            begin
                repeat (2) @(negedge clk);
                bus_if.out_ready = 1'b1;
            end
        join
        repeat (4) @(negedge clk);

        // T6: reset with both stages full; those items must never appear.
        bus_if.out_ready = 1'b0;
        send(16'h4000, 16'h4000, 0);
        send(16'h4200, 16'h4200, 0);
        idle();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t6_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
        check("t6_result", {16'd0, bus_if.result}, 32'd0);
        check("t6_flags", {28'd0, bus_if.nan, bus_if.inexact, bus_if.unf, bus_if.ovf}, 32'd0);
        bus_if.out_ready = 1'b1;
        bp_mode = 0;
        send(16'h4400, 16'h3800, 1);
        idle();

        // Randomized traffic under random backpressure
        bp_mode = 1;
        for (int i = 0; i < 300; i++) begin
            send(rand_op(), rand_op(), 1);
            if ($urandom_range(0, 7) == 0) idle();
        end
        idle();
        bp_mode = 0;

        drain = 0;
        while (exp_q.size() != 0 && drain < 1000) begin
            @(negedge clk);
            drain++;
        end
        repeat (2) @(negedge clk);
        check("drain", exp_q.size(), 32'd0);
        check("idle_out_valid", {31'd0, bus_if.out_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
